// File: rtl/win_avg_pkg.sv
// Shared constants and packing helpers for the windowed averager.
// A sample word holds 2*CHANNELS signed components, I then Q for each channel.
package win_avg_pkg;

    localparam logic MODE_SLIDE = 1'b0;
    localparam logic MODE_BLOCK = 1'b1;

    // Component index of channel ch: I is even, Q is odd.
    function automatic int comp_index(input int ch, input bit is_q);
        return 2 * ch + (is_q ? 1 : 0);
    endfunction

    // LSB position of a component inside the packed sample word.
    function automatic int comp_lsb(input int comp, input int bits);
        return comp * bits;
    endfunction

endpackage

// File: rtl/win_avg_ring.sv
// Circular sample history with a write port and an asynchronous read port
// addressed as an offset back from the write pointer.
module win_avg_ring #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] back,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (we) wr_ptr_d = wr_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_ptr_q <= '0;
        else     wr_ptr_q <= wr_ptr_d;
    end

    // Contents need no reset: the fill counter masks stale entries.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= wdata;
    end

    // back == 0 addresses the oldest slot when the window spans the whole ring.
    assign rdata = mem[wr_ptr_q - back];

endmodule

// File: rtl/sliding_win_avg.sv
// Multichannel complex averager over a 2^win_log2 window, sliding or block
// (decimating), AXI-Stream in and out with a single output register.
module sliding_win_avg
    import win_avg_pkg::*;
#(
    parameter int CHANNELS     = 16,
    parameter int BITS         = 16,
    parameter int MAX_WIN_LOG2 = 5
) (
    input  logic                                aclk,
    input  logic                                arst,
    input  logic [$clog2(MAX_WIN_LOG2+1)-1:0]   win_log2,
    input  logic                                mode,
    input  logic [CHANNELS*2*BITS-1:0]          s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [CHANNELS*2*BITS-1:0]          m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready
);

    localparam int WL_W   = $clog2(MAX_WIN_LOG2 + 1);
    localparam int NCOMP  = 2 * CHANNELS;
    localparam int DW     = NCOMP * BITS;
    localparam int ACC_W  = BITS + MAX_WIN_LOG2;
    localparam int FILL_W = MAX_WIN_LOG2 + 1;

    logic [WL_W-1:0]   win_eff;
    logic [FILL_W-1:0] win_len;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              m_valid_q, m_valid_d;
    logic [DW-1:0]     m_data_q, m_data_d;
    logic [WL_W-1:0]   win_prev_q, win_prev_d;
    logic              mode_prev_q, mode_prev_d;
    logic              cfg_seen_q, cfg_seen_d;

    logic          s_ready, fire, take, slide, full, last;
    logic          cfg_chg, acc_clr, out_load;
    logic [DW-1:0] ring_rd, avg_all;

    assign win_eff = (win_log2 > WL_W'(MAX_WIN_LOG2)) ? WL_W'(MAX_WIN_LOG2) : win_log2;
    assign win_len = FILL_W'(1) << win_eff;

    assign s_ready = !m_valid_q || m_axis_tready;
    assign fire    = s_axis_tvalid && s_ready;
    // The first cycle after reset has no previous config to compare with.
    assign cfg_chg = cfg_seen_q && ((win_log2 != win_prev_q) || (mode != mode_prev_q));
    assign take    = fire && !cfg_chg;
    assign slide   = (mode == MODE_SLIDE);
    assign full    = (fill_q == win_len);
    assign last    = (fill_q == win_len - 1'b1);

    win_avg_ring #(
        .DEPTH_LOG2 (MAX_WIN_LOG2),
        .WIDTH      (DW)
    ) u_ring (
        .clk   (aclk),
        .rst   (arst),
        .we    (take && slide),
        .wdata (s_axis_tdata),
        .back  (win_len[MAX_WIN_LOG2-1:0]),
        .rdata (ring_rd)
    );

    always_comb begin
        fill_d      = fill_q;
        win_prev_d  = win_log2;
        mode_prev_d = mode;
        cfg_seen_d  = 1'b1;
        out_load    = take && (last || (slide && full));
        acc_clr     = cfg_chg || (take && !slide && last);
        if (cfg_chg) begin
            fill_d = '0;
        end else if (take) begin
            if (slide) fill_d = full ? fill_q : fill_q + 1'b1;
            else       fill_d = last ? '0 : fill_q + 1'b1;
        end
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (out_load) begin
            m_valid_d = 1'b1;
            m_data_d  = avg_all;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            fill_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            win_prev_q  <= '0;
            mode_prev_q <= 1'b0;
            cfg_seen_q  <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            win_prev_q  <= win_prev_d;
            mode_prev_q <= mode_prev_d;
            cfg_seen_q  <= cfg_seen_d;
        end
    end

    // One accumulator per I/Q component; the window sum always fits in ACC_W.
    for (genvar k = 0; k < NCOMP; k++) begin : g_comp
        logic signed [BITS-1:0]  new_v, old_v;
        logic signed [ACC_W-1:0] acc_q, acc_d, sum;

        always_comb begin
            new_v = s_axis_tdata[comp_lsb(k, BITS) +: BITS];
            old_v = '0;
            if (slide && full) old_v = ring_rd[comp_lsb(k, BITS) +: BITS];
            sum   = acc_q + ACC_W'(new_v) - ACC_W'(old_v);
            acc_d = acc_q;
            if (acc_clr)   acc_d = '0;
            else if (take) acc_d = sum;
        end

        always_ff @(posedge aclk or posedge arst) begin
            if (arst) acc_q <= '0;
            else      acc_q <= acc_d;
        end

        assign avg_all[comp_lsb(k, BITS) +: BITS] = BITS'(sum >>> win_eff);
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;

endmodule

// File: tb/tb_sliding_win_avg.sv
// Directed bench for sliding_win_avg: vector table for the ramps, hand-written
// sequences for W=1, full scale, clamping, backpressure, config change and reset.
module tb_sliding_win_avg;

    localparam int CH    = 2;
    localparam int BITS  = 16;
    localparam int MAXW  = 5;
    localparam int NCOMP = 2 * CH;
    localparam int DW    = NCOMP * BITS;

    logic          aclk = 1'b0;
    logic          arst;
    logic [2:0]    win_log2;
    logic          mode;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;

    int total = 0;
    int bad   = 0;

    sliding_win_avg #(
        .CHANNELS     (CH),
        .BITS         (BITS),
        .MAX_WIN_LOG2 (MAXW)
    ) dut (
        .aclk          (aclk),
        .arst          (arst),
        .win_log2      (win_log2),
        .mode          (mode),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          win;
        logic        md;
        int          sel;
        logic        vld;
        logic [15:0] din;
        logic        rdy;
        logic        exp_v;
        logic [15:0] exp_d;
    } vec_t;

    function automatic logic [DW-1:0] one_comp(input int sel, input logic [15:0] v);
        logic [DW-1:0] r;
        r = '0;
        r[sel*BITS +: BITS] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] all_comp(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < NCOMP; i++) r[i*BITS +: BITS] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int w, input logic md);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        win_log2      = 3'(w);
        mode          = md;
        arst          = 1'b1;
        step();
        step();
        arst = 1'b0;
        step();
    endtask

    // Drive one beat, clock it, and check the output register afterwards.
    task automatic beat(input string name, input logic [DW-1:0] d, input logic rdy,
                        input logic exp_v, input logic [DW-1:0] exp_d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        step();
        chk({name, " valid"}, DW'(m_axis_tvalid), DW'(exp_v));
        if (exp_v) chk({name, " data"}, m_axis_tdata, exp_d);
    endtask

    vec_t tbl[16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d, hold_val;
        logic          rdy, acc_in, held;
        int            sent, got, k, e;
        logic [15:0]   bp_exp [5];
        logic [15:0]   e16;

        tbl = '{
            '{2, 1'b0, 0, 1'b1, 16'd1,     1'b1, 1'b0, 16'd0},
            '{2, 1'b0, 0, 1'b1, 16'd2,     1'b1, 1'b0, 16'd0},
            '{2, 1'b0, 0, 1'b1, 16'd3,     1'b1, 1'b0, 16'd0},
            '{2, 1'b0, 0, 1'b1, 16'd4,     1'b1, 1'b1, 16'd2},
            '{2, 1'b0, 0, 1'b1, 16'd5,     1'b1, 1'b1, 16'd3},
            '{2, 1'b0, 0, 1'b1, 16'd6,     1'b1, 1'b1, 16'd4},
            '{2, 1'b0, 0, 1'b0, 16'd0,     1'b1, 1'b0, 16'd0},
            '{2, 1'b1, 1, 1'b1, 16'd5,     1'b1, 1'b0, 16'd0},
            '{2, 1'b1, 1, 1'b1, 16'd6,     1'b1, 1'b0, 16'd0},
            '{2, 1'b1, 1, 1'b1, 16'd7,     1'b1, 1'b0, 16'd0},
            '{2, 1'b1, 1, 1'b1, 16'd8,     1'b1, 1'b1, 16'd6},
            '{2, 1'b1, 1, 1'b1, 16'hFFFF,  1'b1, 1'b0, 16'd0},
            '{2, 1'b1, 1, 1'b1, 16'hFFFE,  1'b1, 1'b0, 16'd0},
            '{2, 1'b1, 1, 1'b1, 16'hFFFD,  1'b1, 1'b0, 16'd0},
            '{2, 1'b1, 1, 1'b1, 16'hFFFD,  1'b1, 1'b1, 16'hFFFD},
            '{2, 1'b1, 1, 1'b0, 16'd0,     1'b1, 1'b0, 16'd0}
        };
        bp_exp = '{16'd25, 16'd35, 16'd45, 16'd55, 16'd65};

        // Reset state
        arst = 1'b1; win_log2 = 3'd2; mode = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        #1;
        chk("reset valid", DW'(m_axis_tvalid), DW'(0));
        chk("reset data", m_axis_tdata, '0);
        chk("reset ready", DW'(s_axis_tready), DW'(1));

        // Sliding and block ramps
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || tbl[i].win != tbl[i-1].win || tbl[i].md != tbl[i-1].md)
                do_reset(tbl[i].win, tbl[i].md);
            s_axis_tvalid = tbl[i].vld;
            s_axis_tdata  = one_comp(tbl[i].sel, tbl[i].din);
            m_axis_tready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d valid", i), DW'(m_axis_tvalid), DW'(tbl[i].exp_v));
            if (tbl[i].exp_v)
                chk($sformatf("vec%0d data", i), m_axis_tdata, one_comp(tbl[i].sel, tbl[i].exp_d));
        end

        // W=1 pass-through
        do_reset(0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d = {$urandom(), $urandom()};
            beat($sformatf("w1 beat%0d", i), d, 1'b1, 1'b1, d);
        end

        // Full-scale window of 32, then all negative
        do_reset(5, 1'b0);
        for (int b = 1; b <= 80; b++) begin
            if (b <= 40) begin
                beat($sformatf("fs beat%0d", b), all_comp(16'h7FFF), 1'b1, b >= 32, all_comp(16'h7FFF));
            end else begin
                k   = (b - 40 > 32) ? 32 : b - 40;
                e   = (32 * 32767 - k * 65535) >>> 5;
                e16 = 16'(e);
                beat($sformatf("fs beat%0d", b), all_comp(16'h8000), 1'b1, 1'b1, all_comp(e16));
            end
        end
        chk("fs final", m_axis_tdata, all_comp(16'h8000));

        // Out-of-range win_log2 behaves as the maximum window
        do_reset(7, 1'b0);
        for (int b = 1; b <= 32; b++)
            beat($sformatf("clamp beat%0d", b), all_comp(16'd3), 1'b1, b == 32, all_comp(16'd3));

        // Backpressure: downstream ready pattern 1,0,0,1
        do_reset(2, 1'b0);
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            m_axis_tready = rdy;
            s_axis_tvalid = (sent < 8);
            s_axis_tdata  = one_comp(0, 16'(10 * (sent + 1)));
            #1;
            chk($sformatf("bp ready c%0d", cyc), DW'(s_axis_tready), DW'(!m_axis_tvalid || rdy));
            acc_in   = s_axis_tvalid && s_axis_tready;
            held     = m_axis_tvalid && !rdy;
            hold_val = m_axis_tdata;
            if (m_axis_tvalid && rdy) begin
                chk($sformatf("bp out%0d", got), m_axis_tdata, one_comp(0, bp_exp[got]));
                got++;
            end
            @(posedge aclk); #1;
            if (held) begin
                chk($sformatf("bp hold valid c%0d", cyc), DW'(m_axis_tvalid), DW'(1));
                chk($sformatf("bp hold data c%0d", cyc), m_axis_tdata, hold_val);
            end
            if (acc_in) sent++;
        end
        chk("bp count", DW'(got), DW'(5));
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        step(); step();
        chk("bp no extra", DW'(m_axis_tvalid), DW'(0));

        // Config change with a pending beat, then restart window of 8
        do_reset(2, 1'b0);
        for (int b = 1; b <= 6; b++)
            beat($sformatf("cc pre%0d", b), one_comp(0, 16'd8), 1'b1, b >= 4, one_comp(0, 16'd8));
        win_log2 = 3'd3;
        beat("cc change", one_comp(0, 16'd100), 1'b0, 1'b1, one_comp(0, 16'd8));
        for (int b = 1; b <= 8; b++)
            beat($sformatf("cc post%0d", b), one_comp(0, 16'd16), 1'b1, b == 8, one_comp(0, 16'd16));
        // A sample accepted on the change cycle must not enter the window
        win_log2 = 3'd2;
        beat("cc discard", one_comp(0, 16'd1000), 1'b1, 1'b0, '0);
        for (int b = 1; b <= 4; b++)
            beat($sformatf("cc w4 %0d", b), one_comp(0, 16'd4), 1'b1, b == 4, one_comp(0, 16'd4));

        // Asynchronous reset while a beat is pending
        beat("rst pend", one_comp(0, 16'd4), 1'b0, 1'b1, one_comp(0, 16'd4));
        #2 arst = 1'b1;
        #1;
        chk("async rst valid", DW'(m_axis_tvalid), DW'(0));
        chk("async rst data", m_axis_tdata, '0);
        chk("async rst ready", DW'(s_axis_tready), DW'(1));
        step();
        arst = 1'b0;
        for (int b = 1; b <= 4; b++)
            beat($sformatf("after rst %0d", b), one_comp(0, 16'd12), 1'b1, b == 4, one_comp(0, 16'd12));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
